// File: rtl/spi_slave_regs_if.sv
// SPI pin bundle between a serial master and the register-file responder.
// The master drives select, clock and data; the slave returns miso and its enable.
interface spi_slave_regs_if;
  logic n_cs;
  logic sclk;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output n_cs, sclk, mosi, input miso, miso_oe);
  modport slave  (input n_cs, sclk, mosi, output miso, miso_oe);
endinterface

// File: rtl/spi_slave_regs.sv
// SPI responder with an oversampled pin front end and a 2^ADDR_W x 8 register file.
// Frames are a command byte (R/nW + start address) followed by auto-incrementing data bytes.
module spi_slave_regs #(
  parameter bit         CPOL      = 1'b1,
  parameter bit         CPHA      = 1'b0,
  parameter int         ADDR_W    = 4,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic                       clk,
  input  logic                       rst,
  spi_slave_regs_if.slave            spi,
  input  logic                       loc_we,
  input  logic [ADDR_W-1:0]          loc_addr,
  input  logic [7:0]                 loc_data,
  output logic [8*(2**ADDR_W)-1:0]   regs_out,
  output logic                       wr_pulse,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [7:0]                 wr_data,
  output logic                       busy
);

  localparam int NREG = 2**ADDR_W;

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_t;

  state_t            state_q, state_d;
  logic [1:0]        ncs_sync_q, ncs_sync_d;
  logic [2:0]        sclk_sync_q, sclk_sync_d;
  logic [1:0]        mosi_sync_q, mosi_sync_d;
  logic [1:0]        vld_q, vld_d;
  logic              armed_q, armed_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        rx_sr_q, rx_sr_d;
  logic [7:0]        tx_sr_q, tx_sr_d;
  logic              miso_q, miso_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_pulse_q, wr_pulse_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [7:0]        regs_q [NREG];
  logic [7:0]        regs_d [NREG];

  logic              ncs_s, rise, fall, lead, trail, sample_edge, shift_edge;
  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] addr_inc;

  assign ncs_s       = ncs_sync_q[1];
  assign rise        = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign fall        = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign lead        = CPOL ? fall : rise;
  assign trail       = CPOL ? rise : fall;
  assign sample_edge = CPHA ? trail : lead;
  assign shift_edge  = CPHA ? lead : trail;
  assign rx_byte     = {rx_sr_q, mosi_sync_q[1]};
  assign addr_inc    = addr_q + 1'b1;

  always_comb begin
    ncs_sync_d  = {ncs_sync_q[0], spi.n_cs};
    sclk_sync_d = {sclk_sync_q[1:0], spi.sclk};
    mosi_sync_d = {mosi_sync_q[0], spi.mosi};
    // vld marks when the synchronizer holds real pin data rather than reset fill,
    // so a select already low at reset release never looks like a fresh fall.
    vld_d       = {vld_q[0], 1'b1};
    armed_d     = armed_q | (vld_q[1] & ncs_s);
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    miso_d      = miso_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wr_pulse_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    regs_d      = regs_q;
    if (loc_we) regs_d[loc_addr] = loc_data;

    case (state_q)
      ST_IDLE: begin
        if (armed_q && !ncs_s) begin
          state_d   = ST_CMD;
          bit_cnt_d = 3'd0;
          tx_sr_d   = 8'h00;
          miso_d    = 1'b0;
        end
      end
      default: begin
        if (ncs_s) begin
          state_d = ST_IDLE;
        end else begin
          if (shift_edge) begin
            miso_d  = tx_sr_q[7];
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
          end
          if (sample_edge) begin
            rx_sr_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == ST_CMD) begin
                state_d = ST_DATA;
                rw_d    = rx_byte[7];
                addr_d  = rx_byte[ADDR_W-1:0];
                tx_sr_d = rx_byte[7] ? regs_q[rx_byte[ADDR_W-1:0]] : 8'h00;
              end else if (rw_q) begin
                addr_d  = addr_inc;
                tx_sr_d = regs_q[addr_inc];
              end else begin
                // Applied after the local write so the SPI master wins a same-cycle collision.
                regs_d[addr_q] = rx_byte;
                wr_pulse_d     = 1'b1;
                wr_addr_d      = addr_q;
                wr_data_d      = rx_byte;
                addr_d         = addr_inc;
                tx_sr_d        = 8'h00;
              end
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ncs_sync_q  <= 2'b11;
      sclk_sync_q <= {3{CPOL}};
      mosi_sync_q <= 2'b00;
      vld_q       <= 2'b00;
      armed_q     <= 1'b0;
      bit_cnt_q   <= 3'd0;
      rx_sr_q     <= 7'd0;
      tx_sr_q     <= 8'h00;
      miso_q      <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wr_pulse_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
      for (int i = 0; i < NREG; i++) regs_q[i] <= RESET_VAL;
    end else begin
      state_q     <= state_d;
      ncs_sync_q  <= ncs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      vld_q       <= vld_d;
      armed_q     <= armed_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      miso_q      <= miso_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wr_pulse_q  <= wr_pulse_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      regs_q      <= regs_d;
    end
  end

  for (genvar gi = 0; gi < NREG; gi++) begin : g_out
    assign regs_out[8*gi +: 8] = regs_q[gi];
  end

  assign spi.miso    = miso_q;
  assign spi.miso_oe = ~ncs_s;
  assign wr_pulse    = wr_pulse_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
